// File: rtl/freq_seg_display_if.sv
// Bus between the frequency counter and the 7-segment display block.
// The slave side is the display; the master side drives frequency and observes the outputs.
interface freq_seg_display_if;
    logic [13:0] frequency;
    logic [15:0] bcd;
    logic        conv_done;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output frequency,
        input  bcd, conv_done, overflow, an, seg, dp
    );

    modport slave (
        input  frequency,
        output bcd, conv_done, overflow, an, seg, dp
    );
endinterface

// File: rtl/freq_seg_display.sv
// Binary-to-BCD conversion (sequential double-dabble) and 4-digit multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module freq_seg_display #(
    parameter int REFRESH_DIV = 100_000,
    parameter int MAX_DISPLAY = 9999
) (
    input logic                clock,
    input logic                reset,
    freq_seg_display_if.slave  bus
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t        state_q;
    logic [13:0]   shift_q;
    logic [13:0]   last_q;
    logic [15:0]   acc_q;
    logic [3:0]    iter_q;
    logic          last_valid_q;
    logic [15:0]   bcd_q;
    logic          conv_done_q;
    logic          overflow_q;

    logic [RW-1:0] refresh_q;
    logic [1:0]    scan_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic [15:0]   acc_adj;
    logic [15:0]   acc_shift_d;
    logic [3:0]    digit;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // Shift-add-3 step; the bit leaving nibble 3 is the ten-thousands carry and is dropped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3
                                                          : acc_q[4*i +: 4];
        end
        acc_shift_d = 16'({acc_adj, shift_q[13]});
    end

    // Outputs are loaded on entry to COMMIT so bcd/conv_done are valid during the COMMIT cycle.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            last_q       <= '0;
            acc_q        <= '0;
            iter_q       <= '0;
            last_valid_q <= 1'b0;
            bcd_q        <= '0;
            conv_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            conv_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!last_valid_q || (bus.frequency != last_q)) state_q <= LOAD;
                end
                LOAD: begin
                    shift_q <= bus.frequency;
                    last_q  <= bus.frequency;
                    acc_q   <= '0;
                    iter_q  <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    acc_q   <= acc_shift_d;
                    shift_q <= {shift_q[12:0], 1'b0};
                    iter_q  <= iter_q + 4'd1;
                    if (iter_q == 4'd13) begin
                        state_q      <= COMMIT;
                        bcd_q        <= acc_shift_d;
                        conv_done_q  <= 1'b1;
                        overflow_q   <= ({18'd0, last_q} > 32'(MAX_DISPLAY));
                        last_valid_q <= 1'b1;
                    end
                end
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        digit = bcd_q[{scan_q, 2'b00} +: 4];
        an_d  = ~(4'b0001 << scan_q);
        seg_d = seg_code(digit);
`ifdef LEADING_ZERO_BLANK_EN
        case (scan_q)
            2'd3:    if (bcd_q[15:12] == 4'd0) seg_d = SEG_BLANK;
            2'd2:    if (bcd_q[15:8]  == 8'd0) seg_d = SEG_BLANK;
            2'd1:    if (bcd_q[15:4]  == 12'd0) seg_d = SEG_BLANK;
            default: ;
        endcase
`else
`endif
        if (overflow_q) seg_d = SEG_DASH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            refresh_q <= '0;
            scan_q    <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            if (refresh_q == RW'(REFRESH_DIV - 1)) begin
                refresh_q <= '0;
                scan_q    <= scan_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.conv_done = conv_done_q;
    assign bus.overflow  = overflow_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = 1'b1;

endmodule

// File: doc/freq_seg_display.md
Name: freq_seg_display

Overview:
- Downstream consumer of the 14-bit frequency counter output.
- Converts the binary frequency to 4 BCD digits with a sequential double-dabble (shift-add-3) engine.
- Drives the board's 4-digit common-anode 7-segment display through a time-multiplexed scan.
- Runs in the same 100 MHz domain as the counter.

Parameters:
- REFRESH_DIV, 100_000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range ≥ 2.
- MAX_DISPLAY, 9999: largest value shown numerically; anything above it is overflow.

Ports:
- clock  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- frequency  input  14  binary value from the frequency counter; may change on any cycle
- bcd  output  16  registered converted digits {thousands, hundreds, tens, ones}, 4 bits each
- conv_done  output  1  one-cycle pulse when bcd/display digits are committed
- overflow  output  1  registered; 1 while the committed value exceeds MAX_DISPLAY
- an  output  4  digit enables, active low; an[0] = rightmost (ones)
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low; constant 1 (off)

Behaviour:
- Reset values:
  - bcd=0, conv_done=0, overflow=0.
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Scan index=0, refresh count=0.
  - Internal "last valid" flag=0; FSM state=IDLE.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
- IDLE:
  - Go to LOAD when the last-valid flag is 0, or when frequency != last converted value.
  - Otherwise remain in IDLE.
- LOAD (1 cycle):
  - Capture frequency into the shift register and the last-converted register.
  - Clear the 16-bit BCD accumulator and the iteration counter.
- SHIFT (exactly 14 cycles):
  - Each cycle, add 3 to every accumulator nibble ≥ 5.
  - Then shift {accumulator, shift register} left by 1.
  - After iteration 14, go to COMMIT.
- COMMIT (1 cycle):
  - bcd <= accumulator; conv_done=1 for this cycle only.
  - overflow <= (captured value > MAX_DISPLAY); last-valid flag <= 1.
  - Return to IDLE.
- Latency: frequency change sampled in IDLE at cycle N → LOAD at N+1 → SHIFT N+2..N+15 → COMMIT N+16 (bcd and conv_done valid at N+16).
- Changes of frequency during LOAD/SHIFT/COMMIT are ignored for the running conversion. They are detected on the first IDLE cycle afterwards, and a new conversion starts. No value is lost except intermediate values superseded before IDLE.
- Range handling:
  - The BCD value for inputs up to 16383 fits in 5 digits. The engine keeps 16 bits, so the ten-thousands carry is discarded.
  - When overflow=1, all four digits show dash (seg=7'b0111111) regardless of bcd.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
  - an and seg are registered, one cycle behind the scan index.
  - Exactly one an bit is low at any time after the first post-reset cycle.
  - The digit shown is always from the last committed bcd, never from the in-progress accumulator.
- Segment codes (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
- Reset asserted mid-conversion or mid-scan: all state returns to reset values on the next clock edge. A fresh conversion starts from IDLE after reset deasserts.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined: higher-order zero digits above the most significant non-zero digit show blank (seg=7'b1111111) while their an bit still scans. The ones digit is never blanked, so 0 shows "   0" and 205 shows " 205". Overflow dashes are unaffected.
- Undefined: all four digits always displayed, e.g. "0205".

Test Plan:
- Reset held 3 cycles, frequency=0: an=1111, seg=1111111 during reset. conv_done pulses 16 cycles after release; bcd=16'h0000.
- frequency=1234, REFRESH_DIV=4: bcd=16'h1234 at COMMIT. Scanning an=1110/1101/1011/0111 shows seg 0011001/0110000/0100100/1111001, each held 4 cycles.
- frequency=9999 then 10000: first commit bcd=16'h9999, overflow=0. Second commit overflow=1, all digits seg=0111111.
- frequency changes 500→700 three cycles into SHIFT: first commit bcd=16'h0500, a second conversion starts automatically, and the next conv_done gives bcd=16'h0700.
- Steady frequency=42 for 1000 cycles: exactly one conv_done pulse. With LEADING_ZERO_BLANK_EN, digits 3 and 2 are blank and the display reads "  42"; without it, "0042".
- Reset asserted at SHIFT iteration 7: next cycle all outputs are at reset values and no conv_done appears for the aborted conversion.
